// File: rtl/multiplier_iter_fx.sv
// Iterative signed multiplier: one shift-add step per clock, subtract on the MSB
// step, plus a fixed-point result with configurable shift, rounding and saturation.
module multiplier_iter_fx #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned OUT_SHIFT = 7,
  parameter int unsigned ROUND_EN  = 1,
  parameter int unsigned SAT_EN    = 1
) (
  input  logic                  I_CLK,
  input  logic                  I_RST_N,
  input  logic                  I_VALID,
  output logic                  O_READY,
  input  logic [DATA_W-1:0]     I_IN1,
  input  logic [DATA_W-1:0]     I_IN2,
  output logic                  O_VALID,
  input  logic                  I_READY,
  output logic [2*DATA_W-1:0]   O_OUT_2N,
  output logic [DATA_W-1:0]     O_OUT_N,
  output logic                  O_OVF
);

  localparam int unsigned PW    = 2 * DATA_W;
  localparam int unsigned EW    = PW + 1;
  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam int unsigned UW    = EW - DATA_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [PW-1:0]       acc_q, acc_d;
  logic [CNT_W-1:0]    k_q, k_d;
  logic                ready_q, ready_d;
  logic                valid_q, valid_d;
  logic [PW-1:0]       out2n_q, out2n_d;
  logic [DATA_W-1:0]   outn_q, outn_d;
  logic                ovf_q, ovf_d;

  logic [PW-1:0]       a_ext;
  logic [PW-1:0]       term;
  logic [PW-1:0]       acc_step;
  logic                last_step;
  logic [EW-1:0]       p_ext;
  logic [EW-1:0]       rnd_add;
  logic [EW-1:0]       sum_ext;
  logic [EW-1:0]       t_val;
  logic [UW-1:0]       t_upper;
  logic                ovf_c;
  logic [DATA_W-1:0]   outn_c;

  // One multiplier step: add (or subtract on the sign bit) the shifted multiplicand.
  always_comb begin
    a_ext     = {{DATA_W{a_q[DATA_W-1]}}, a_q};
    term      = a_ext << k_q;
    last_step = (k_q == CNT_W'(DATA_W - 1));
    acc_step  = acc_q;
    if (b_q[k_q]) begin
      if (last_step) begin
        acc_step = acc_q - term;
      end else begin
        acc_step = acc_q + term;
      end
    end
  end

  // Fixed-point result from the product: round, arithmetic shift, range check, clamp.
  always_comb begin
    p_ext   = {acc_step[PW-1], acc_step};
    rnd_add = (ROUND_EN != 0) ? (EW'(1) << (OUT_SHIFT - 1)) : '0;
    sum_ext = p_ext + rnd_add;
    t_val   = EW'($signed(sum_ext) >>> OUT_SHIFT);
    t_upper = t_val[EW-1:DATA_W-1];
    ovf_c   = ~((&t_upper) | (~|t_upper));
    outn_c  = t_val[DATA_W-1:0];
    if ((SAT_EN != 0) && ovf_c) begin
      outn_c = t_val[EW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  // Next-state and register-input logic for the IDLE/CALC/DONE sequencer.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    k_d     = k_q;
    ready_d = ready_q;
    valid_d = valid_q;
    out2n_d = out2n_q;
    outn_d  = outn_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (I_VALID) begin
          a_d     = I_IN1;
          b_d     = I_IN2;
          acc_d   = '0;
          k_d     = '0;
          ready_d = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_step;
        k_d   = k_q + CNT_W'(1);
        if (last_step) begin
          k_d     = '0;
          out2n_d = acc_step;
          outn_d  = outn_c;
          ovf_d   = ovf_c;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (I_READY) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and datapath registers; reset aborts any in-flight operation.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      k_q     <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      out2n_q <= '0;
      outn_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      out2n_q <= out2n_d;
      outn_q  <= outn_d;
      ovf_q   <= ovf_d;
    end
  end

  assign O_READY  = ready_q;
  assign O_VALID  = valid_q;
  assign O_OUT_2N = out2n_q;
  assign O_OUT_N  = outn_q;
  assign O_OVF    = ovf_q;

endmodule

// File: tb/tb_multiplier_iter_fx.sv
// Bench for multiplier_iter_fx: three configurations (round+sat, round+wrap,
// truncate+sat) share stimulus and are checked against an arithmetic model.
module tb_multiplier_iter_fx;

  localparam int DW = 8;
  localparam int SH = 7;

  logic clk = 1'b0;
  logic rst_n;
  logic i_valid;
  logic i_ready;
  logic [DW-1:0] in1, in2;

  logic [2:0]           rdy, vld, ovf;
  logic [2:0][2*DW-1:0] o2n;
  logic [2:0][DW-1:0]   on;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multiplier_iter_fx #(.DATA_W(DW), .OUT_SHIFT(SH), .ROUND_EN(1), .SAT_EN(1)) u_dut (
    .I_CLK(clk), .I_RST_N(rst_n), .I_VALID(i_valid), .O_READY(rdy[0]),
    .I_IN1(in1), .I_IN2(in2), .O_VALID(vld[0]), .I_READY(i_ready),
    .O_OUT_2N(o2n[0]), .O_OUT_N(on[0]), .O_OVF(ovf[0]));

  multiplier_iter_fx #(.DATA_W(DW), .OUT_SHIFT(SH), .ROUND_EN(1), .SAT_EN(0)) u_nosat (
    .I_CLK(clk), .I_RST_N(rst_n), .I_VALID(i_valid), .O_READY(rdy[1]),
    .I_IN1(in1), .I_IN2(in2), .O_VALID(vld[1]), .I_READY(i_ready),
    .O_OUT_2N(o2n[1]), .O_OUT_N(on[1]), .O_OVF(ovf[1]));

  multiplier_iter_fx #(.DATA_W(DW), .OUT_SHIFT(SH), .ROUND_EN(0), .SAT_EN(1)) u_trunc (
    .I_CLK(clk), .I_RST_N(rst_n), .I_VALID(i_valid), .O_READY(rdy[2]),
    .I_IN1(in1), .I_IN2(in2), .O_VALID(vld[2]), .I_READY(i_ready),
    .O_OUT_2N(o2n[2]), .O_OUT_N(on[2]), .O_OVF(ovf[2]));

  // Count a comparison and report it when observed differs from expected.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact product, then floor-shift with optional half-up rounding.
  task automatic model(input int a, input int b, input bit rnd, input bit sat,
                       output logic [2*DW-1:0] p2n, output logic [DW-1:0] n,
                       output logic v);
    longint p, t, maxv, minv;
    p    = longint'(a) * longint'(b);
    t    = rnd ? ((p + (longint'(1) << (SH - 1))) >>> SH) : (p >>> SH);
    maxv = (longint'(1) << (DW - 1)) - 1;
    minv = -(longint'(1) << (DW - 1));
    v    = (t > maxv) || (t < minv);
    if (sat && v) n = (t < 0) ? DW'(minv) : DW'(maxv);
    else          n = DW'(t);
    p2n  = (2*DW)'(p);
  endtask

  task automatic check_results(input int a, input int b, input string phase);
    logic [2*DW-1:0] p2n;
    logic [DW-1:0]   n;
    logic            v;
    for (int i = 0; i < 3; i++) begin
      model(a, b, (i != 2), (i != 1), p2n, n, v);
      check($sformatf("%s out_2n[%0d] %0d*%0d", phase, i, a, b), 64'(o2n[i]), 64'(p2n));
      check($sformatf("%s out_n[%0d] %0d*%0d", phase, i, a, b), 64'(on[i]), 64'(n));
      check($sformatf("%s ovf[%0d] %0d*%0d", phase, i, a, b), 64'(ovf[i]), 64'(v));
      check($sformatf("%s valid[%0d]", phase, i), 64'(vld[i]), 64'(1));
    end
  endtask

  // One full transaction; called and returns at #1 after a rising edge, FSM in IDLE.
  task automatic do_op(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
                       input int hold, input bit ready_in_calc);
    int cyc;
    check("ready_idle", 64'(rdy[0]), 64'(1));
    i_valid = 1'b1;
    in1     = a;
    in2     = b;
    i_ready = ready_in_calc;
    @(posedge clk); #1;
    i_valid = 1'($urandom_range(0, 1));
    in1     = DW'($urandom);
    in2     = DW'($urandom);
    cyc = 0;
    while (!vld[0] && cyc < 3 * DW) begin
      check("ready_calc", 64'(rdy[0]), 64'(0));
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 64'(cyc), 64'(DW));
    check_results(int'(a), int'(b), "done");
    check("ready_done", 64'(rdy[0]), 64'(0));
    i_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      i_valid = 1'b1;
      in1     = DW'($urandom);
      in2     = DW'($urandom);
      @(posedge clk); #1;
      check_results(int'(a), int'(b), "hold");
      check("ready_hold", 64'(rdy[0]), 64'(0));
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    check("valid_drop", 64'(vld[0]), 64'(0));
    check("ready_back", 64'(rdy[0]), 64'(1));
  endtask

  initial begin
    logic seen;
    int   ra, rb;
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    in1     = '0;
    in2     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst ready", 64'(rdy[0]), 64'(1));
    check("rst valid", 64'(vld[0]), 64'(0));
    check("rst out_2n", 64'(o2n[0]), 64'(0));
    check("rst out_n", 64'(on[0]), 64'(0));
    check("rst ovf", 64'(ovf[0]), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases, including extremes and rounding direction.
    do_op(8'sd64, 8'sd64, 0, 1'b1);
    do_op(-8'sd128, -8'sd128, 0, 1'b0);
    do_op(-8'sd128, 8'sd127, 1, 1'b1);
    do_op(8'sd0, -8'sd1, 0, 1'b0);
    do_op(8'sd3, 8'sd64, 0, 1'b1);
    do_op(8'sd127, 8'sd127, 5, 1'b0);
    do_op(8'sd0, -8'sd128, 0, 1'b0);
    do_op(-8'sd3, 8'sd64, 0, 1'b0);

    // Asynchronous reset between edges while in CALC discards the operation.
    i_valid = 1'b1;
    in1     = 8'sd100;
    in2     = -8'sd77;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort ready", 64'(rdy[0]), 64'(1));
    check("abort valid", 64'(vld[0]), 64'(0));
    check("abort out_2n", 64'(o2n[0]), 64'(0));
    check("abort out_n", 64'(on[0]), 64'(0));
    check("abort ovf", 64'(ovf[0]), 64'(0));
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    seen = 1'b0;
    for (int c = 0; c < 2 * DW; c++) begin
      seen = seen | vld[0];
      @(posedge clk); #1;
    end
    check("abort no_valid", 64'(seen), 64'(0));
    do_op(-8'sd5, 8'sd7, 0, 1'b0);

    // Randomised operands, biased toward extreme and zero values.
    for (int r = 0; r < 40; r++) begin
      ra = $urandom_range(0, 255);
      rb = $urandom_range(0, 255);
      case ($urandom_range(0, 7))
        0: ra = 128;
        1: rb = 128;
        2: ra = 0;
        3: rb = 127;
        default: ;
      endcase
      do_op(DW'(ra), DW'(rb), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multiplier_iter_fx.md
Name: multiplier_iter_fx

Overview:
- Parametrised, iterative, signed two's-complement multiplier with a valid/ready handshake on both sides.
- Computes the full 2*DATA_W-bit product using one shift-add step per clock; the MSB step is a subtract.
- Also produces a DATA_W-bit fixed-point result with configurable binary-point shift, optional rounding and optional saturation.
- Used by the MHA datapath wherever area matters more than throughput, e.g. scaling and softmax normalisation.

Parameters:
- DATA_W, 8: operand width in bits, signed; legal range 2..32.
- OUT_SHIFT, 7: arithmetic right shift applied to the product to form O_OUT_N. The default gives Q1.7 x Q1.7 -> Q1.7. Legal range 1..DATA_W.
- ROUND_EN, 1: 1 = round half up before the shift; 0 = truncate (floor).
- SAT_EN, 1: 1 = clamp O_OUT_N to the signed DATA_W range; 0 = wrap (keep the low DATA_W bits).

Ports:
- I_CLK, in, 1: clock, rising edge.
- I_RST_N, in, 1: reset, asynchronous, active-low.
- I_VALID, in, 1: operands valid.
- O_READY, out, 1: block can accept operands.
- I_IN1, in, DATA_W: multiplicand A, signed.
- I_IN2, in, DATA_W: multiplier B, signed.
- O_VALID, out, 1: result valid.
- I_READY, in, 1: downstream accepts the result.
- O_OUT_2N, out, 2*DATA_W: full signed product A*B.
- O_OUT_N, out, DATA_W: shifted, rounded and saturated product.
- O_OVF, out, 1: the shifted value does not fit in signed DATA_W.

Behaviour:
- Reset:
  - I_RST_N low clears the block immediately, independent of the clock.
  - State goes to IDLE; accumulator and counter clear.
  - O_VALID=0, O_OUT_2N=0, O_OUT_N=0, O_OVF=0, O_READY=1.
  - Asserting reset mid-operation discards the in-flight operation. No result is produced for it.
- FSM states: IDLE, CALC, DONE.
  - IDLE: O_READY=1. When I_VALID=1 at a rising edge:
    - latch A and B;
    - clear the 2*DATA_W accumulator and set step counter k=0;
    - go to CALC.
  - CALC: O_READY=0. Each clock, if B[k]=1:
    - for k<DATA_W-1: acc += sign_ext(A)<<k;
    - for k=DATA_W-1: acc -= sign_ext(A)<<k.
    - All arithmetic is 2*DATA_W bits wide and wraps modulo 2^(2*DATA_W).
    - After step k=DATA_W-1, register the outputs and go to DONE.
  - DONE: O_VALID=1; O_OUT_* and O_OVF are held stable. When I_READY=1 at an edge: O_VALID goes to 0 and the FSM goes to IDLE.
- Latency and throughput:
  - O_VALID rises DATA_W clocks after the accepting edge.
  - The result is held for as long as I_READY=0.
  - Minimum initiation interval is DATA_W+2 clocks.
- Input handling:
  - I_IN1/I_IN2 changes after the accepting edge are ignored.
  - I_VALID is ignored outside IDLE; no queueing.
  - A source must hold I_VALID until it sees O_READY=1 at an edge.
- O_OUT_N formation, evaluated once when entering DONE (P = exact product):
  - Rounding: if ROUND_EN=1, T = (P + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT, computed in 2*DATA_W+1 bits so the add cannot overflow. Otherwise T = P >>> OUT_SHIFT.
  - Overflow: O_OVF=1 iff T > 2^(DATA_W-1)-1 or T < -2^(DATA_W-1). This is independent of SAT_EN.
  - Saturation: if SAT_EN=1 and O_OVF=1, O_OUT_N = +max or -min according to the sign of T. Otherwise O_OUT_N = T[DATA_W-1:0].
- Boundary cases:
  - A=-2^(DATA_W-1), B=-2^(DATA_W-1): P is exact (+2^(2*DATA_W-2)). It fits O_OUT_2N; O_OUT_N overflows.
  - A=0 or B=0: P=0, O_OVF=0.
- Simultaneous events:
  - I_READY=1 on the same edge as CALC->DONE has no effect; O_VALID must be high for at least one cycle.
  - Reset wins over any handshake.

Test Plan (DATA_W=8, OUT_SHIFT=7, ROUND_EN=1, SAT_EN=1 unless stated):
1. A=64, B=64, I_READY=1 -> O_VALID high exactly 8 clocks after accept; O_OUT_2N=0x1000, O_OUT_N=0x20, O_OVF=0; O_READY=0 throughout CALC/DONE.
2. A=-128, B=-128 -> O_OUT_2N=0x4000, O_OUT_N=0x7F, O_OVF=1. Repeat with SAT_EN=0 -> O_OUT_N=0x80, O_OVF=1.
3. A=-128, B=127 -> O_OUT_2N=0xC080, O_OUT_N=0x81, O_OVF=0. Also A=0, B=-1 -> all zero, O_OVF=0.
4. Rounding:
   - A=3, B=64 -> 0x00C0, O_OUT_N=0x02 (ROUND_EN=0: 0x01).
   - A=-3, B=64 -> 0xFF40, O_OUT_N=0xFF (ROUND_EN=0: 0xFE).
5. Hold I_READY=0 for 5 cycles in DONE while driving I_VALID=1 with new operands -> O_VALID stays 1, outputs unchanged, O_READY=0, new operands not taken. After I_READY=1, the next accepted operation yields the correct product.
6. Pulse I_RST_N low mid-CALC (step 4), asynchronously between edges -> outputs go to 0 and O_READY to 1 immediately, with no O_VALID for the aborted operation. A following A=-5, B=7 gives 0xFFDD.
